// File: rtl/video_timing_mon.sv
// Passive raster monitor on the transmit video path: measures line/frame geometry
// from vs/hs/de, compares it with the expected format and reports lock and sticky errors.
module video_timing_mon #(
    parameter int X_BITS           = 12,
    parameter int Y_BITS           = 12,
    parameter int EXP_H_TOTAL      = 1650,
    parameter int EXP_H_ACTIVE     = 1280,
    parameter int EXP_V_TOTAL      = 750,
    parameter int EXP_V_ACTIVE     = 720,
    parameter int SYNC_ACTIVE_HIGH = 1,
    parameter int LOCK_FRAMES      = 2,
    parameter int FRAME_TIMEOUT    = 4194304
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vs_in,
    input  logic              hs_in,
    input  logic              de_in,
    input  logic              clear,
    output logic [X_BITS-1:0] h_total,
    output logic [X_BITS-1:0] h_active,
    output logic [Y_BITS-1:0] v_total,
    output logic [Y_BITS-1:0] v_active,
    output logic [15:0]       frame_count,
    output logic              meas_valid,
    output logic              locked,
    output logic              err_sticky
);

    localparam logic              SYNC_INV = (SYNC_ACTIVE_HIGH == 0);
    localparam int                TO_W     = $clog2(FRAME_TIMEOUT + 2);
    localparam int                GW       = $clog2(LOCK_FRAMES + 1);
    localparam logic [X_BITS-1:0] EXP_HT   = X_BITS'(EXP_H_TOTAL);
    localparam logic [X_BITS-1:0] EXP_HA   = X_BITS'(EXP_H_ACTIVE);
    localparam logic [Y_BITS-1:0] EXP_VT   = Y_BITS'(EXP_V_TOTAL);
    localparam logic [Y_BITS-1:0] EXP_VA   = Y_BITS'(EXP_V_ACTIVE);
    localparam logic [TO_W-1:0]   TO_LIM   = TO_W'(FRAME_TIMEOUT);
    localparam logic [TO_W-1:0]   TO_HOLD  = TO_W'(FRAME_TIMEOUT + 1);
    localparam logic [GW-1:0]     GOOD_MAX = GW'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        S_SEARCH,
        S_FIRST,
        S_MEASURE
    } state_t;

    state_t state_q, state_d;

    logic vs_q, hs_q, de_q, vs_p, hs_p;
    logic [1:0] primed;
    logic vs_edge, hs_edge;

    logic [X_BITS-1:0] h_cnt, de_cnt, last_len, ref_active;
    logic [Y_BITS-1:0] line_cnt, act_cnt;
    logic              frame_bad;
    logic [TO_W-1:0]   gap_cnt;
    logic [GW-1:0]     good_cnt;

    logic [X_BITS-1:0] line_len, last_len_nx, ref_nx;
    logic [Y_BITS-1:0] line_cnt_nx, act_cnt_nx;
    logic              bad_nx, frame_good, timeout, publish, acc_clear, err_set;
    logic [GW-1:0]     good_nx;

    // primed masks the bogus edge that the zeroed history would create right after reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            vs_q   <= 1'b0;
            hs_q   <= 1'b0;
            de_q   <= 1'b0;
            vs_p   <= 1'b0;
            hs_p   <= 1'b0;
            primed <= 2'b00;
        end else begin
            vs_q   <= vs_in ^ SYNC_INV;
            hs_q   <= hs_in ^ SYNC_INV;
            de_q   <= de_in;
            vs_p   <= vs_q;
            hs_p   <= hs_q;
            primed <= {primed[0], 1'b1};
        end
    end

    assign vs_edge = primed[1] & vs_q & ~vs_p;
    assign hs_edge = primed[1] & hs_q & ~hs_p;
    assign timeout = ~vs_edge & (gap_cnt == TO_LIM);

    // Line close folded into next-values so a coincident vs edge publishes the closed line
    always_comb begin
        line_len    = (h_cnt == '1) ? h_cnt : h_cnt + 1'b1;
        line_cnt_nx = line_cnt;
        act_cnt_nx  = act_cnt;
        ref_nx      = ref_active;
        bad_nx      = frame_bad;
        last_len_nx = last_len;
        if (hs_edge) begin
            if (line_cnt != '1) line_cnt_nx = line_cnt + 1'b1;
            if (line_len != last_len) bad_nx = 1'b1;
            last_len_nx = line_len;
            if (de_cnt != '0) begin
                if (act_cnt == '0) ref_nx = de_cnt;
                else if (de_cnt != ref_active) bad_nx = 1'b1;
                if (act_cnt != '1) act_cnt_nx = act_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        frame_good = ~bad_nx && (last_len_nx == EXP_HT) && (ref_nx == EXP_HA) &&
                     (line_cnt_nx == EXP_VT) && (act_cnt_nx == EXP_VA);
        good_nx    = (good_cnt == GOOD_MAX) ? good_cnt : good_cnt + 1'b1;
        err_set    = locked & ((publish & ~frame_good) | timeout);
    end

    always_comb begin
        state_d   = state_q;
        publish   = 1'b0;
        acc_clear = 1'b0;
        if (timeout) begin
            state_d = S_SEARCH;
        end else if (vs_edge) begin
            acc_clear = 1'b1;
            case (state_q)
                S_SEARCH:  state_d = S_FIRST;
                S_FIRST:   state_d = S_MEASURE;
                S_MEASURE: publish = 1'b1;
                default:   state_d = S_SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) state_q <= S_SEARCH;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            h_cnt      <= '0;
            de_cnt     <= '0;
            last_len   <= '0;
            ref_active <= '0;
            line_cnt   <= '0;
            act_cnt    <= '0;
            frame_bad  <= 1'b0;
            gap_cnt    <= '0;
        end else begin
            if (hs_edge)           h_cnt <= '0;
            else if (h_cnt != '1)  h_cnt <= h_cnt + 1'b1;

            if (hs_edge)                   de_cnt <= de_q ? X_BITS'(1) : '0;
            else if (de_q && de_cnt != '1) de_cnt <= de_cnt + 1'b1;

            last_len <= last_len_nx;

            if (acc_clear) begin
                ref_active <= '0;
                line_cnt   <= '0;
                act_cnt    <= '0;
                frame_bad  <= 1'b0;
            end else begin
                ref_active <= ref_nx;
                line_cnt   <= line_cnt_nx;
                act_cnt    <= act_cnt_nx;
                frame_bad  <= bad_nx;
            end

            if (vs_edge)                gap_cnt <= '0;
            else if (gap_cnt != TO_HOLD) gap_cnt <= gap_cnt + 1'b1;
        end
    end

    // Published results, lock tracking and the sticky error flag (set beats clear)
    always_ff @(posedge clk) begin
        if (!reset) begin
            h_total     <= '0;
            h_active    <= '0;
            v_total     <= '0;
            v_active    <= '0;
            frame_count <= '0;
            meas_valid  <= 1'b0;
            locked      <= 1'b0;
            err_sticky  <= 1'b0;
            good_cnt    <= '0;
        end else begin
            meas_valid <= publish;
            if (publish) begin
                h_total     <= last_len_nx;
                h_active    <= ref_nx;
                v_total     <= line_cnt_nx;
                v_active    <= act_cnt_nx;
                frame_count <= frame_count + 16'd1;
                if (frame_good) begin
                    good_cnt <= good_nx;
                    if (good_nx == GOOD_MAX) locked <= 1'b1;
                end else begin
                    good_cnt <= '0;
                    locked   <= 1'b0;
                end
            end
            if (timeout) begin
                good_cnt <= '0;
                locked   <= 1'b0;
            end
            err_sticky <= err_set | (err_sticky & ~clear);
        end
    end

endmodule
